// File: rtl/axi_mem_arbiter_if.sv
// rtl/axi_mem_arbiter_if.sv - AXI4 read/write channel bundle shared by the cache ports and the DRAM port
interface axi_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              arvalid;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              awvalid;
    logic [AW-1:0]     awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awready;
    logic              wvalid;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        input rdata, rresp, rlast, rvalid, output rready,
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input arvalid, araddr, arlen, arsize, arburst, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input awvalid, awaddr, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - merges cache D/I ports onto one AXI4 master (RR reads, D-only writes)
module axi_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_LEN = 3
) (
    input  logic              clk,
    input  logic              resetn,
    axi_mem_arbiter_if.slave  s_d,
    axi_mem_arbiter_if.slave  s_i,
    axi_mem_arbiter_if.master m,
    output logic              prot_err
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_RESP} wr_state_t;

    rd_state_t     rd_state, rd_next;
    wr_state_t     wr_state, wr_next;
    logic          owner_i, last_i, gnt_i, r_hs, w_hs, err_set;
    logic [7:0]    beat_cnt, ar_len_q, aw_len_q;
    logic [AW-1:0] ar_addr_q, aw_addr_q;
    logic [2:0]    ar_size_q, aw_size_q;
    logic [1:0]    ar_burst_q, aw_burst_q;
    logic          aw_done, w_done;
    logic          unused_i_wr;

    assign r_hs = (rd_state == RD_DATA) && m.rvalid && (owner_i ? s_i.rready : s_d.rready);
    assign w_hs = (wr_state == WR_ACTIVE) && !w_done && s_d.wvalid && m.wready;

    // Read FSM: owner ar/r channels are wired straight through while the transaction is live
    always_comb begin
        rd_next    = rd_state;
        gnt_i      = 1'b0;
        s_d.arready = 1'b0;
        s_i.arready = 1'b0;
        s_d.rvalid  = 1'b0;
        s_i.rvalid  = 1'b0;
        m.arvalid   = 1'b0;
        m.rready    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (s_d.arvalid || s_i.arvalid) begin
                    rd_next = RD_ADDR;
                    gnt_i   = s_i.arvalid && (!s_d.arvalid || !last_i);
                end
            end
            RD_ADDR: begin
                m.arvalid = 1'b1;
                if (owner_i) s_i.arready = m.arready;
                else         s_d.arready = m.arready;
                if (m.arready) rd_next = RD_DATA;
            end
            RD_DATA: begin
                m.rready   = owner_i ? s_i.rready : s_d.rready;
                s_i.rvalid = owner_i && m.rvalid;
                s_d.rvalid = !owner_i && m.rvalid;
                if (r_hs && m.rlast) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state   <= RD_IDLE;
            owner_i    <= 1'b0;
            last_i     <= 1'b1;
            beat_cnt   <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && rd_next == RD_ADDR) begin
                owner_i    <= gnt_i;
                beat_cnt   <= '0;
                ar_addr_q  <= gnt_i ? s_i.araddr  : s_d.araddr;
                ar_len_q   <= gnt_i ? s_i.arlen   : s_d.arlen;
                ar_size_q  <= gnt_i ? s_i.arsize  : s_d.arsize;
                ar_burst_q <= gnt_i ? s_i.arburst : s_d.arburst;
            end
            if (r_hs) begin
                if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                if (m.rlast) last_i <= owner_i;
            end
        end
    end

    assign m.araddr  = ar_addr_q;
    assign m.arlen   = ar_len_q;
    assign m.arsize  = ar_size_q;
    assign m.arburst = ar_burst_q;
    assign s_d.rdata = m.rdata;
    assign s_d.rresp = m.rresp;
    assign s_d.rlast = m.rlast;
    assign s_i.rdata = m.rdata;
    assign s_i.rresp = m.rresp;
    assign s_i.rlast = m.rlast;

    // Write FSM: AW and W complete in either order; B only after both
    always_comb begin
        wr_next     = wr_state;
        m.awvalid   = 1'b0;
        m.wvalid    = 1'b0;
        m.bready    = 1'b0;
        s_d.awready = 1'b0;
        s_d.wready  = 1'b0;
        s_d.bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: if (s_d.awvalid) wr_next = WR_ACTIVE;
            WR_ACTIVE: begin
                m.awvalid   = !aw_done;
                s_d.awready = !aw_done && m.awready;
                m.wvalid    = !w_done && s_d.wvalid;
                s_d.wready  = !w_done && m.wready;
                if ((aw_done || m.awready) && (w_done || w_hs)) wr_next = WR_RESP;
            end
            WR_RESP: begin
                s_d.bvalid = m.bvalid;
                m.bready   = s_d.bready;
                if (m.bvalid && s_d.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state   <= WR_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == WR_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (s_d.awvalid) begin
                    aw_addr_q  <= s_d.awaddr;
                    aw_len_q   <= s_d.awlen;
                    aw_size_q  <= s_d.awsize;
                    aw_burst_q <= s_d.awburst;
                end
            end
            if (wr_state == WR_ACTIVE && m.awready) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
        end
    end

    assign m.awaddr  = aw_addr_q;
    assign m.awlen   = aw_len_q;
    assign m.awsize  = aw_size_q;
    assign m.awburst = aw_burst_q;
    assign m.wdata   = s_d.wdata;
    assign m.wstrb   = s_d.wstrb[SW-1:0];
    assign m.wlast   = s_d.wlast;
    assign s_d.bresp = m.bresp;

    // The instruction port is read-only: its write channels are never acknowledged
    assign s_i.awready = 1'b0;
    assign s_i.wready  = 1'b0;
    assign s_i.bvalid  = 1'b0;
    assign s_i.bresp   = 2'b00;
    assign unused_i_wr = ^{s_i.awaddr, s_i.awlen, s_i.awsize, s_i.awburst,
                           s_i.wvalid, s_i.wdata, s_i.wstrb, s_i.wlast, s_i.bready};

    assign err_set = (rd_state == RD_IDLE && rd_next == RD_ADDR &&
                      ((gnt_i ? s_i.arlen : s_d.arlen) > 8'(MAX_LEN)))
                   || (r_hs && m.rlast && beat_cnt != ar_len_q)
                   || (r_hs && !m.rlast && beat_cnt >= ar_len_q)
                   || (wr_state == WR_IDLE && s_d.awvalid && s_d.awlen != 8'd0)
                   || (w_hs && !s_d.wlast)
                   || s_i.awvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      prot_err <= 1'b0;
        else if (err_set) prot_err <= 1'b1;
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter
module tb_axi_mem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic prot_err;
    int   n_assert = 0;
    int   n_fail = 0;
    int   ar_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, awv_cnt = 0, i_wr_act = 0;
    int   base_ar, base_aw, base_w, base_awv;
    logic [31:0] beats [4];

    axi_mem_arbiter_if #(.AW(32), .DW(32)) s_d_bus ();
    axi_mem_arbiter_if #(.AW(32), .DW(32)) s_i_bus ();
    axi_mem_arbiter_if #(.AW(32), .DW(32)) m_bus ();

    axi_mem_arbiter #(.AW(32), .DW(32), .MAX_LEN(3)) dut (
        .clk(clk), .resetn(resetn),
        .s_d(s_d_bus), .s_i(s_i_bus), .m(m_bus),
        .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_bus.arvalid && m_bus.arready) ar_hs_cnt++;
        if (m_bus.awvalid && m_bus.awready) aw_hs_cnt++;
        if (m_bus.wvalid && m_bus.wready) w_hs_cnt++;
        if (m_bus.awvalid) awv_cnt++;
        if (s_i_bus.awready || s_i_bus.wready || s_i_bus.bvalid) i_wr_act++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the arbiter sits in RD_ADDR for the given owner
    task automatic ar_phase(input bit own_i, input logic [31:0] addr, input logic [7:0] len);
        check("m_arvalid", m_bus.arvalid, 1);
        check("m_araddr", m_bus.araddr, addr);
        check("m_arlen", m_bus.arlen, len);
        m_bus.arready = 1'b1;
        #1;
        check("owner_arready", own_i ? s_i_bus.arready : s_d_bus.arready, 1);
        check("other_arready", own_i ? s_d_bus.arready : s_i_bus.arready, 0);
        @(negedge clk);
        m_bus.arready = 1'b0;
        if (own_i) s_i_bus.arvalid = 1'b0;
        else       s_d_bus.arvalid = 1'b0;
    endtask

    task automatic slave_r(input bit own_i, input int n, input int last_beat, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            m_bus.rvalid = 1'b1;
            m_bus.rdata  = base + 32'(b);
            m_bus.rresp  = 2'b00;
            m_bus.rlast  = (b == last_beat);
            s_i_bus.rready = own_i;
            s_d_bus.rready = !own_i;
            #1;
            check("owner_rvalid", own_i ? s_i_bus.rvalid : s_d_bus.rvalid, 1);
            check("owner_rdata", own_i ? s_i_bus.rdata : s_d_bus.rdata, base + 32'(b));
            check("owner_rlast", own_i ? s_i_bus.rlast : s_d_bus.rlast, (b == last_beat));
            check("other_rvalid", own_i ? s_d_bus.rvalid : s_i_bus.rvalid, 0);
            @(negedge clk);
        end
        m_bus.rvalid = 1'b0;
        m_bus.rlast  = 1'b0;
        s_i_bus.rready = 1'b0;
        s_d_bus.rready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_ar(input bit port_i, input logic [31:0] addr, input logic [7:0] len);
        if (port_i) begin
            s_i_bus.arvalid = 1'b1; s_i_bus.araddr = addr; s_i_bus.arlen = len;
            s_i_bus.arsize = 3'd2;  s_i_bus.arburst = 2'd1;
        end else begin
            s_d_bus.arvalid = 1'b1; s_d_bus.araddr = addr; s_d_bus.arlen = len;
            s_d_bus.arsize = 3'd2;  s_d_bus.arburst = 2'd1;
        end
    endtask

    initial begin
        {s_d_bus.arvalid, s_d_bus.araddr, s_d_bus.arlen, s_d_bus.arsize, s_d_bus.arburst, s_d_bus.rready} = '0;
        {s_d_bus.awvalid, s_d_bus.awaddr, s_d_bus.awlen, s_d_bus.awsize, s_d_bus.awburst} = '0;
        {s_d_bus.wvalid, s_d_bus.wdata, s_d_bus.wstrb, s_d_bus.wlast, s_d_bus.bready} = '0;
        {s_i_bus.arvalid, s_i_bus.araddr, s_i_bus.arlen, s_i_bus.arsize, s_i_bus.arburst, s_i_bus.rready} = '0;
        {s_i_bus.awvalid, s_i_bus.awaddr, s_i_bus.awlen, s_i_bus.awsize, s_i_bus.awburst} = '0;
        {s_i_bus.wvalid, s_i_bus.wdata, s_i_bus.wstrb, s_i_bus.wlast, s_i_bus.bready} = '0;
        {m_bus.arready, m_bus.rdata, m_bus.rresp, m_bus.rlast, m_bus.rvalid} = '0;
        {m_bus.awready, m_bus.wready, m_bus.bresp, m_bus.bvalid} = '0;
        beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC; beats[3] = 32'hD;

        // Reset state
        @(negedge clk);
        check("rst_m_arvalid", m_bus.arvalid, 0);
        check("rst_m_awvalid", m_bus.awvalid, 0);
        check("rst_d_arready", s_d_bus.arready, 0);
        check("rst_d_awready", s_d_bus.awready, 0);
        check("rst_prot_err", prot_err, 0);
        resetn = 1'b1;

        // I read 0x100 len3 alone, beats A..D
        base_ar = ar_hs_cnt;
        set_ar(1, 32'h100, 8'd3);
        #1;
        check("t1_no_early_arvalid", m_bus.arvalid, 0);
        @(negedge clk);
        ar_phase(1, 32'h100, 8'd3);
        check("t1_arvalid_dropped", m_bus.arvalid, 0);
        for (int b = 0; b < 4; b++) begin
            m_bus.rvalid = 1'b1; m_bus.rdata = beats[b]; m_bus.rlast = (b == 3);
            s_i_bus.rready = 1'b1;
            #1;
            check("t1_i_rvalid", s_i_bus.rvalid, 1);
            check("t1_i_rdata", s_i_bus.rdata, beats[b]);
            check("t1_i_rlast", s_i_bus.rlast, (b == 3));
            check("t1_d_rvalid", s_d_bus.rvalid, 0);
            @(negedge clk);
        end
        m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0; s_i_bus.rready = 1'b0;
        check("t1_ar_count", ar_hs_cnt - base_ar, 1);
        check("t1_prot_err", prot_err, 0);

        // Simultaneous D and I after reset: D first, then I, then D wins the next contest
        do_reset();
        set_ar(0, 32'h40, 8'd1);
        set_ar(1, 32'h80, 8'd0);
        @(negedge clk);
        ar_phase(0, 32'h40, 8'd1);
        slave_r(0, 2, 1, 32'h4000);
        check("t2_idle_gap", m_bus.arvalid, 0);
        @(negedge clk);
        ar_phase(1, 32'h80, 8'd0);
        slave_r(1, 1, 0, 32'h8000);
        set_ar(0, 32'h44, 8'd0);
        set_ar(1, 32'h84, 8'd0);
        @(negedge clk);
        ar_phase(0, 32'h44, 8'd0);
        slave_r(0, 1, 0, 32'h4400);
        @(negedge clk);
        ar_phase(1, 32'h84, 8'd0);
        slave_r(1, 1, 0, 32'h8400);
        check("t2_prot_err", prot_err, 0);

        // D write, slave wready three cycles ahead of awready
        base_aw = aw_hs_cnt; base_w = w_hs_cnt;
        s_d_bus.awvalid = 1'b1; s_d_bus.awaddr = 32'h200; s_d_bus.awlen = 8'd0;
        s_d_bus.awsize = 3'd2;  s_d_bus.awburst = 2'd1;
        s_d_bus.wvalid = 1'b1;  s_d_bus.wdata = 32'hDEADBEEF; s_d_bus.wstrb = 4'hF; s_d_bus.wlast = 1'b1;
        @(negedge clk);
        check("t3_m_awvalid", m_bus.awvalid, 1);
        check("t3_m_awaddr", m_bus.awaddr, 32'h200);
        check("t3_m_wvalid", m_bus.wvalid, 1);
        check("t3_m_wdata", m_bus.wdata, 32'hDEADBEEF);
        check("t3_m_wstrb", m_bus.wstrb, 4'hF);
        m_bus.wready = 1'b1;
        #1;
        check("t3_d_wready", s_d_bus.wready, 1);
        @(negedge clk);
        s_d_bus.wvalid = 1'b0; m_bus.wready = 1'b0;
        #1;
        check("t3_w_done_wvalid", m_bus.wvalid, 0);
        @(negedge clk);
        @(negedge clk);
        check("t3_aw_still_valid", m_bus.awvalid, 1);
        check("t3_d_awready_wait", s_d_bus.awready, 0);
        m_bus.awready = 1'b1;
        #1;
        check("t3_d_awready", s_d_bus.awready, 1);
        @(negedge clk);
        s_d_bus.awvalid = 1'b0; m_bus.awready = 1'b0;
        check("t3_awvalid_after", m_bus.awvalid, 0);
        m_bus.bvalid = 1'b1; m_bus.bresp = 2'b00; s_d_bus.bready = 1'b1;
        #1;
        check("t3_d_bvalid", s_d_bus.bvalid, 1);
        check("t3_d_bresp", s_d_bus.bresp, 2'b00);
        check("t3_m_bready", m_bus.bready, 1);
        @(negedge clk);
        m_bus.bvalid = 1'b0; s_d_bus.bready = 1'b0;
        #1;
        check("t3_d_bvalid_done", s_d_bus.bvalid, 0);
        check("t3_aw_count", aw_hs_cnt - base_aw, 1);
        check("t3_w_count", w_hs_cnt - base_w, 1);
        check("t3_i_write_idle", i_wr_act, 0);
        check("t3_prot_err", prot_err, 0);

        // Early rlast on beat 2 of a len3 burst, then a clean read
        @(negedge clk);
        set_ar(0, 32'h300, 8'd3);
        @(negedge clk);
        ar_phase(0, 32'h300, 8'd3);
        slave_r(0, 3, 2, 32'h3000);
        check("t4_prot_err_set", prot_err, 1);
        set_ar(1, 32'h400, 8'd0);
        @(negedge clk);
        ar_phase(1, 32'h400, 8'd0);
        slave_r(1, 1, 0, 32'h4000);
        check("t4_prot_err_sticky", prot_err, 1);

        // Asynchronous reset in the middle of beat 1
        do_reset();
        check("t5_prot_err_cleared", prot_err, 0);
        set_ar(0, 32'h600, 8'd3);
        @(negedge clk);
        ar_phase(0, 32'h600, 8'd3);
        slave_r(0, 1, 9, 32'h6000);
        m_bus.rvalid = 1'b1; m_bus.rdata = 32'h6001; s_d_bus.rready = 1'b1;
        #1;
        check("t5_beat1_rvalid", s_d_bus.rvalid, 1);
        resetn = 1'b0;
        #1;
        check("t5_async_rvalid", s_d_bus.rvalid, 0);
        check("t5_async_rready", m_bus.rready, 0);
        check("t5_async_arvalid", m_bus.arvalid, 0);
        m_bus.rvalid = 1'b0; s_d_bus.rready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        set_ar(1, 32'h500, 8'd1);
        @(negedge clk);
        ar_phase(1, 32'h500, 8'd1);
        slave_r(1, 2, 1, 32'h5000);
        check("t5_prot_err", prot_err, 0);

        // Write attempt on the instruction port
        base_awv = awv_cnt;
        s_i_bus.awvalid = 1'b1; s_i_bus.awaddr = 32'h700;
        #1;
        check("t6_i_awready", s_i_bus.awready, 0);
        @(negedge clk);
        check("t6_prot_err", prot_err, 1);
        check("t6_i_awready_hold", s_i_bus.awready, 0);
        s_i_bus.awvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_prot_err_sticky", prot_err, 1);
        check("t6_no_m_awvalid", awv_cnt - base_awv, 0);
        check("t6_i_write_idle", i_wr_act, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
